// File: rtl/reset_sequencer_if.sv
// Signal bundle between the reset sequencer and the logic it supervises.
// The sequencer drives through "master"; downstream consumers use "slave".
interface reset_sequencer_if;
    logic locked;
    logic rst_out;
    logic ready;
    logic ce_a;
    logic ce_b;
    logic unlock_seen;

    modport master (
        input  locked,
        output rst_out,
        output ready,
        output ce_a,
        output ce_b,
        output unlock_seen
    );

    modport slave (
        output locked,
        input  rst_out,
        input  ready,
        input  ce_a,
        input  ce_b,
        input  unlock_seen
    );
endinterface

// File: rtl/reset_sequencer.sv
// Holds downstream logic in reset until the DCM lock has been stable for HOLD_CYCLES,
// then releases it and generates two clock-enable pulse trains.
module reset_sequencer #(
    parameter int HOLD_CYCLES = 1024,
    parameter int CE_A_DIV    = 6,
    parameter int CE_B_DIV    = 3
) (
    input  logic               clock,
    input  logic               reset,
    reset_sequencer_if.master  bus
);
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int DIVA_W = (CE_A_DIV > 1) ? $clog2(CE_A_DIV) : 1;
    localparam int DIVB_W = (CE_B_DIV > 1) ? $clog2(CE_B_DIV) : 1;

    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [DIVA_W-1:0] DIVA_MAX = DIVA_W'(CE_A_DIV - 1);
    localparam logic [DIVB_W-1:0] DIVB_MAX = DIVB_W'(CE_B_DIV - 1);

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                sync1_q, sync1_d;
    logic                sync2_q, sync2_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [DIVA_W-1:0]   diva_cnt_q, diva_cnt_d;
    logic [DIVB_W-1:0]   divb_cnt_q, divb_cnt_d;
    logic                unlock_q, unlock_d;
    logic                lock_s;
    logic                run_s;

    assign lock_s = sync2_q;
    assign run_s  = (state_q == ST_RUN);

    // State, synchronizer and counter registers; reset wins over every other event.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_WAIT;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            hold_cnt_q <= '0;
            diva_cnt_q <= '0;
            divb_cnt_q <= '0;
            unlock_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            hold_cnt_q <= hold_cnt_d;
            diva_cnt_q <= diva_cnt_d;
            divb_cnt_q <= divb_cnt_d;
            unlock_q   <= unlock_d;
        end
    end

    // Next-state logic; counters default to zero so they restart cleanly on every entry.
    always_comb begin
        state_d    = state_q;
        sync1_d    = bus.locked;
        sync2_d    = sync1_q;
        hold_cnt_d = '0;
        diva_cnt_d = '0;
        divb_cnt_d = '0;
        unlock_d   = unlock_q;
        case (state_q)
            ST_WAIT: begin
                if (lock_s) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (!lock_s) begin
                    state_d  = ST_WAIT;
                    unlock_d = 1'b1;
                end else if (hold_cnt_q == HOLD_MAX) begin
                    state_d = ST_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_d  = ST_WAIT;
                    unlock_d = 1'b1;
                end else begin
                    diva_cnt_d = (diva_cnt_q == DIVA_MAX) ? '0 : diva_cnt_q + DIVA_W'(1);
                    divb_cnt_d = (divb_cnt_q == DIVB_MAX) ? '0 : divb_cnt_q + DIVB_W'(1);
                end
            end
            default: begin
                state_d = ST_WAIT;
            end
        endcase
    end

    // Outputs decode registered state only, so enables are gated off whenever reset is out.
    assign bus.rst_out     = !run_s;
    assign bus.ready       = run_s;
    assign bus.ce_a        = run_s && (diva_cnt_q == DIVA_MAX);
    assign bus.ce_b        = run_s && (divb_cnt_q == DIVB_MAX);
    assign bus.unlock_seen = unlock_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default-parameter instance plus a minimal
// HOLD_CYCLES=1 / CE_A_DIV=2 / CE_B_DIV=1 instance.
module tb_reset_sequencer;
    logic clk;
    logic rst_a;
    logic rst_b;
    int   n_cmp;
    int   n_err;

    reset_sequencer_if if_a ();
    reset_sequencer_if if_b ();

    reset_sequencer dut_a (
        .clock (clk),
        .reset (rst_a),
        .bus   (if_a.master)
    );

    reset_sequencer #(
        .HOLD_CYCLES (1),
        .CE_A_DIV    (2),
        .CE_B_DIV    (1)
    ) dut_b (
        .clock (clk),
        .reset (rst_b),
        .bus   (if_b.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
        end
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        if_a.locked = 1'b0;
        if_b.locked = 1'b0;
        ticks(2);

        check("a_reset_rst_out", if_a.rst_out, 1'b1);
        check("a_reset_ready", if_a.ready, 1'b0);
        check("a_reset_ce_a", if_a.ce_a, 1'b0);
        check("a_reset_ce_b", if_a.ce_b, 1'b0);
        check("a_reset_unlock", if_a.unlock_seen, 1'b0);
        check("b_reset_rst_out", if_b.rst_out, 1'b1);
        check("b_reset_ce_b", if_b.ce_b, 1'b0);

        // Small instance: release after E4, ce_b every RUN cycle, ce_a alternating
        rst_b = 1'b0;
        if_b.locked = 1'b1;
        ticks(3);
        check("b_e3_rst_out", if_b.rst_out, 1'b1);
        tick();
        check("b_e4_rst_out", if_b.rst_out, 1'b0);
        check("b_e4_ready", if_b.ready, 1'b1);
        for (int k = 0; k < 8; k++) begin
            logic exp_a;
            exp_a = ((k % 2) == 1);
            check("b_run_ce_a", if_b.ce_a, exp_a);
            check("b_run_ce_b", if_b.ce_b, 1'b1);
            tick();
        end
        if_b.locked = 1'b0;
        ticks(2);
        check("b_drop2_rst_out", if_b.rst_out, 1'b0);
        check("b_drop2_ce_b", if_b.ce_b, 1'b1);
        tick();
        check("b_drop3_rst_out", if_b.rst_out, 1'b1);
        check("b_drop3_ce_a", if_b.ce_a, 1'b0);
        check("b_drop3_ce_b", if_b.ce_b, 1'b0);
        check("b_drop3_unlock", if_b.unlock_seen, 1'b1);

        // Default instance: exact release latency of 1027 edges
        rst_a = 1'b0;
        if_a.locked = 1'b1;
        ticks(1026);
        check("a_e1026_rst_out", if_a.rst_out, 1'b1);
        check("a_e1026_ready", if_a.ready, 1'b0);
        tick();
        check("a_e1027_rst_out", if_a.rst_out, 1'b0);
        check("a_e1027_ready", if_a.ready, 1'b1);
        for (int k = 0; k < 100; k++) begin
            logic exp_a;
            logic exp_b;
            exp_a = ((k % 6) == 5);
            exp_b = ((k % 3) == 2);
            check("a_run_ce_a", if_a.ce_a, exp_a);
            check("a_run_ce_b", if_a.ce_b, exp_b);
            tick();
        end

        // Lock loss in RUN: reset reasserts three edges later
        if_a.locked = 1'b0;
        ticks(2);
        check("a_unlock2_rst_out", if_a.rst_out, 1'b0);
        check("a_unlock2_sticky", if_a.unlock_seen, 1'b0);
        tick();
        check("a_unlock3_rst_out", if_a.rst_out, 1'b1);
        check("a_unlock3_ready", if_a.ready, 1'b0);
        check("a_unlock3_ce_a", if_a.ce_a, 1'b0);
        check("a_unlock3_ce_b", if_a.ce_b, 1'b0);
        check("a_unlock3_sticky", if_a.unlock_seen, 1'b1);

        // Lock lost at HOLD count 500; re-lock needs the full hold again
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        check("a_rst_clears_unlock", if_a.unlock_seen, 1'b0);
        if_a.locked = 1'b1;
        ticks(503);
        if_a.locked = 1'b0;
        ticks(2);
        check("a_hold_drop_rst_out", if_a.rst_out, 1'b1);
        check("a_hold_drop_pre", if_a.unlock_seen, 1'b0);
        tick();
        check("a_hold_drop_unlock", if_a.unlock_seen, 1'b1);
        check("a_hold_drop_rst_out2", if_a.rst_out, 1'b1);
        if_a.locked = 1'b1;
        ticks(1026);
        check("a_relock_e1026", if_a.rst_out, 1'b1);
        tick();
        check("a_relock_e1027", if_a.rst_out, 1'b0);
        check("a_relock_sticky", if_a.unlock_seen, 1'b1);

        // Reset pulse at RUN cycle 50, then full recovery
        ticks(50);
        check("a_run50_ready", if_a.ready, 1'b1);
        rst_a = 1'b1;
        tick();
        check("a_midrun_rst_out", if_a.rst_out, 1'b1);
        check("a_midrun_ready", if_a.ready, 1'b0);
        check("a_midrun_unlock", if_a.unlock_seen, 1'b0);
        check("a_midrun_ce_a", if_a.ce_a, 1'b0);
        check("a_midrun_ce_b", if_a.ce_b, 1'b0);
        rst_a = 1'b0;
        ticks(1026);
        check("a_recover_e1026", if_a.rst_out, 1'b1);
        tick();
        check("a_recover_e1027", if_a.rst_out, 1'b0);

        // One-cycle lock glitch while in WAIT
        rst_a = 1'b1;
        if_a.locked = 1'b0;
        tick();
        rst_a = 1'b0;
        ticks(2);
        if_a.locked = 1'b1;
        tick();
        if_a.locked = 1'b0;
        ticks(2);
        check("a_glitch_hold_rst_out", if_a.rst_out, 1'b1);
        check("a_glitch_hold_unlock", if_a.unlock_seen, 1'b0);
        tick();
        check("a_glitch_wait_unlock", if_a.unlock_seen, 1'b1);
        for (int k = 0; k < 20; k++) begin
            check("a_glitch_rst_out", if_a.rst_out, 1'b1);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter HOLD_CYCLES, default 1024: cycles of stable lock required before reset release; legal range 1..65535.
REQ-002 Parameter CE_A_DIV, default 6: divide ratio of ce_a; legal range 2..255.
REQ-003 Parameter CE_B_DIV, default 3: divide ratio of ce_b; legal range 1..255.
REQ-004 clock  input  1  sole clock; one of the generated DCM outputs, e.g. the 42.857 MHz domain.
REQ-005 reset  input  1  synchronous, active-high; one clock, no other clock domain.
REQ-006 locked  input  1  DCM lock flag; asynchronous to clock.
REQ-007 rst_out  output  1  active-high system reset for downstream logic.
REQ-008 ready  output  1  high only in state RUN.
REQ-009 ce_a  output  1  single-cycle clock-enable pulse, period CE_A_DIV.
REQ-010 ce_b  output  1  single-cycle clock-enable pulse, period CE_B_DIV.
REQ-011 unlock_seen  output  1  sticky flag: lock lost while in HOLD or RUN.

Function
REQ-012 locked SHALL pass through a 2-flop synchronizer (s1, s2) before any use; lock_s = s2.
REQ-013 FSM states: WAIT, HOLD, RUN; all state and counters registered.
REQ-014 WAIT: hold counter = 0, divider counters = 0; lock_s=1 -> HOLD next edge.
REQ-015 HOLD: hold counter +1 per cycle; lock_s=0 -> WAIT (counter cleared); counter == HOLD_CYCLES-1 with lock_s=1 -> RUN.
REQ-016 RUN: lock_s=0 -> WAIT next edge; otherwise remain in RUN.
REQ-017 rst_out = 1 in WAIT and HOLD, 0 in RUN; ready = NOT rst_out; both decoded from the state register only.
REQ-018 With locked stable high from edge E1, rst_out SHALL go low immediately after edge E(HOLD_CYCLES+3); latency is exact.
REQ-019 Divider counters count 0..DIV-1 in RUN only, wrap to 0, and start at 0 on entry to RUN.
REQ-020 ce_x = 1 iff state == RUN and its counter == CE_x_DIV-1; first pulse in the CE_x_DIV-th RUN cycle.
REQ-021 CE_B_DIV = 1: ce_b SHALL be constantly high throughout RUN.
REQ-022 ce_a and ce_b SHALL be 0 whenever rst_out = 1, including the first cycle of RUN exit.
REQ-023 Both dividers share the RUN entry point: ce_a and ce_b coincide every lcm(CE_A_DIV, CE_B_DIV) cycles.
REQ-024 unlock_seen sets on any HOLD->WAIT or RUN->WAIT transition caused by lock_s=0; cleared only by reset.
REQ-025 Counter widths = ceil(log2(max value+1)); no overflow is possible within legal parameter ranges.

Reset
REQ-026 reset=1 at an edge SHALL force state WAIT, s1=s2=0, all counters 0, and unlock_seen=0.
REQ-027 Outputs during and after reset: rst_out=1, ready=0, ce_a=0, ce_b=0, unlock_seen=0.
REQ-028 reset has priority over every lock/FSM event in the same cycle.
REQ-029 reset asserted mid-RUN: outputs return to reset values after that edge.
REQ-030 After reset release, the full sync + HOLD sequence SHALL repeat.

Verification
REQ-031 Defaults; locked high before E1 -> rst_out low after E1027; first ce_a after E1032; first ce_b after E1029.
REQ-032 locked drops at HOLD count 500 -> return to WAIT, unlock_seen=1; re-lock requires a full 1024-cycle hold.
REQ-033 RUN for 100 cycles, then locked=0 -> rst_out=1 and ce_a=ce_b=0 three edges later; unlock_seen=1.
REQ-034 reset pulse at RUN cycle 50 -> rst_out=1, unlock_seen=0 next cycle; recovery after 1027 edges with locked held high.
REQ-035 CE_B_DIV=1, CE_A_DIV=2, HOLD_CYCLES=1 -> rst_out low after E4; ce_b high every RUN cycle; ce_a on alternate cycles.
REQ-036 locked glitching one cycle high while in WAIT -> at most a single HOLD cycle; rst_out never deasserts.
